cci_mpf_wro_hazard_filter: RTL and testbench
============================================

// Module: cci_mpf_wro_hazard_filter
// PURPOSE
// Parametrised successor to the MPF write/read-order shim. It arbitrates NUM_CH request channels into
// one downstream request stream and tracks in-flight writes per hashed-address bucket. Any request that
// would violate write/read ordering against an outstanding write to the same bucket is held back.
// Sits between AFU-side request sources and the FIU-side request path; write completions release buckets.
// PARAMETERS
// NUM_CH      2   number of request channels (>=1)
// ADDR_WIDTH  42  line address width (must be >= 2*HASH_BITS)
// HASH_BITS   9   log2 of bucket count (2**HASH_BITS counters)
// CNT_BITS    4   per-bucket outstanding-write counter width
// MODE        1   0: strict (any req blocked while bucket cnt!=0); 1: RAW-only (reads blocked while cnt!=0; writes pass until cnt saturates)
// TAG_WIDTH   16  opaque request metadata passed through unchanged
// PORTS
// clk          in   1                     clock
// reset_n      in   1                     asynchronous active-low reset
// in_valid     in   NUM_CH                per-channel request valid
// in_ready     out  NUM_CH                per-channel accept (combinational, one-hot or zero)
// in_is_write  in   NUM_CH                1=write, 0=read
// in_addr      in   NUM_CH*ADDR_WIDTH     per-channel line address
// in_tag       in   NUM_CH*TAG_WIDTH      per-channel metadata
// out_valid    out  1                     registered downstream request valid
// out_ready    in   1                     downstream accept
// out_is_write out  1                     granted request type
// out_addr     out  ADDR_WIDTH            granted address
// out_tag      out  TAG_WIDTH             granted metadata
// out_ch       out  $clog2(NUM_CH) (min 1) source channel of granted request
// cpl_valid    in   1                     write completion (one per issued write)
// cpl_addr     in   ADDR_WIDTH            address of completed write
// evt_hazard   out  1                     pulse: some valid channel blocked by hazard this cycle
// err_underflow out 1                     sticky: completion arrived for bucket with cnt==0
// BEHAVIOUR
// - Hash: idx(a) = a[HASH_BITS-1:0] ^ a[2*HASH_BITS-1:HASH_BITS].
// - Reset (async, reset_n=0): all counters 0, out_valid=0, rr pointer=0, err_underflow=0, evt_hazard=0; outputs
//   out_is_write/addr/tag/ch = 0. Mid-operation reset discards the output register and all bucket state.
// - Blocked(c): MODE=0: cnt[idx]!=0 for reads and writes. MODE=1: read -> cnt[idx]!=0; write -> cnt[idx]=={CNT_BITS{1}}.
// - Eligible(c) = in_valid[c] & !Blocked(c). slot_free = !out_valid | out_ready.
// - Grant: when slot_free and any eligible, pick first eligible at or after rr pointer (wrap mod NUM_CH);
//   in_ready[grant]=1 same cycle; rr pointer <= grant+1 (wraps to 0). No grant -> rr pointer unchanged.
// - Output register: on grant, out_* loaded next edge, out_valid=1 (latency 1 cycle). out_valid & !out_ready
//   holds out_* stable; out_valid drops after handshake if no new grant.
// - Counter update on the grant edge (not on downstream handshake): granted write -> cnt[idx]+1.
//   cpl_valid -> cnt[idx(cpl_addr)]-1. Same bucket same cycle -> unchanged. cnt==0 with completion ->
//   no change, err_underflow<=1 (cleared only by reset). Increment never wraps (saturation blocks grant).
// - Blocked evaluation uses current-cycle counter values; completion in cycle N unblocks from cycle N+1.
// - Two channels to same bucket same cycle: only one granted; other re-evaluated next cycle against updated cnt.
// - evt_hazard registered: 1 in cycle N+1 iff in cycle N some in_valid[c] & Blocked(c).
// - in_ready never asserted while slot not free; out_ch identifies channel; tag unmodified.
// TESTING
// 1 Reset: reset_n low mid-traffic -> out_valid=0, in_ready=0, all cnt=0; released, single read passes with 1-cycle latency.
// 2 MODE=1: write A=0x100 ch1 then read A ch0 -> read stalled (evt_hazard=1) until cpl_addr=0x100; read issues cycle after cpl.
// 3 MODE=1, CNT_BITS=2: four writes to 0x200, no completions -> first 3 issue, 4th held; one cpl -> 4th issues next cycle.
// 4 MODE=0: write 0x300 then write 0x300 -> second held until completion; writes to 0x301 (different bucket) flow unblocked.
// 5 Arbitration NUM_CH=3, all valid, no hazards, out_ready=1 -> grants 0,1,2,0,...; out_ready=0 -> out_* stable, no in_ready.
// 6 Simultaneous write-grant and cpl to same bucket with cnt=1 -> cnt stays 1; cpl with cnt=0 -> err_underflow=1 sticky.

Source files
------------

// File: rtl/cci_mpf_wro_hazard_filter.sv
// Round-robin merge of NUM_CH request channels, holding back requests that would reorder against in-flight writes.
// Latency 1 cycle; in_ready asserts only when the output slot is free, and the output holds while out_ready is low.
module cci_mpf_wro_hazard_filter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 42,
  parameter int HASH_BITS  = 9,
  parameter int CNT_BITS   = 4,
  parameter int MODE       = 1,
  parameter int TAG_WIDTH  = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH-1:0]            in_is_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] in_addr,
  input  logic [NUM_CH*TAG_WIDTH-1:0]  in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_is_write,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic [CH_W-1:0]              out_ch,
  input  logic                         cpl_valid,
  input  logic [ADDR_WIDTH-1:0]        cpl_addr,
  output logic                         evt_hazard,
  output logic                         err_underflow
);
  localparam int NB = 1 << HASH_BITS;
  typedef logic [HASH_BITS-1:0] idx_t;
  typedef logic [CNT_BITS-1:0]  cnt_t;

  function automatic idx_t hash_f(input logic [2*HASH_BITS-1:0] a);
    return a[HASH_BITS-1:0] ^ a[2*HASH_BITS-1:HASH_BITS];
  endfunction

  cnt_t                  cnt_q [NB];
  cnt_t                  cnt_d [NB];
  logic [CH_W-1:0]       rr_q, rr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_is_write_q, out_is_write_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic                  evt_hazard_q, evt_hazard_d;
  logic                  err_underflow_q, err_underflow_d;

  logic [NUM_CH-1:0]     blocked, elig;
  logic                  slot_free, hi_vld, lo_vld, gnt_vld, g_write, inc;
  logic [CH_W-1:0]       hi_ch, lo_ch, gnt_ch;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [TAG_WIDTH-1:0]  g_tag;
  idx_t                  inc_idx, dec_idx;
  logic                  unused_cpl_hi;

  assign unused_cpl_hi = ^cpl_addr;
  assign slot_free     = !out_valid_q || out_ready;

  // Strict mode blocks anything touching a busy bucket; RAW mode lets writes through until saturation.
  always_comb begin
    blocked = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (MODE == 0 || !in_is_write[c])
        blocked[c] = cnt_q[hash_f(in_addr[c*ADDR_WIDTH +: 2*HASH_BITS])] != '0;
      else
        blocked[c] = &cnt_q[hash_f(in_addr[c*ADDR_WIDTH +: 2*HASH_BITS])];
    end
    elig = in_valid & ~blocked;
  end

  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_ch  = '0;
    lo_ch  = '0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (elig[c]) begin
        if (c >= int'(rr_q)) begin
          hi_vld = 1'b1;
          hi_ch  = CH_W'(c);
        end else begin
          lo_vld = 1'b1;
          lo_ch  = CH_W'(c);
        end
      end
    end
    gnt_vld = reset_n && slot_free && (hi_vld || lo_vld);
    gnt_ch  = hi_vld ? hi_ch : lo_ch;
  end

  always_comb begin
    in_ready = '0;
    g_write  = 1'b0;
    g_addr   = '0;
    g_tag    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_vld && gnt_ch == CH_W'(c)) begin
        in_ready[c] = 1'b1;
        g_write     = in_is_write[c];
        g_addr      = in_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        g_tag       = in_tag[c*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_comb begin
    rr_d           = rr_q;
    out_valid_d    = out_valid_q && !out_ready;
    out_is_write_d = out_is_write_q;
    out_addr_d     = out_addr_q;
    out_tag_d      = out_tag_q;
    out_ch_d       = out_ch_q;
    if (gnt_vld) begin
      rr_d           = (int'(gnt_ch) == NUM_CH-1) ? '0 : gnt_ch + 1'b1;
      out_valid_d    = 1'b1;
      out_is_write_d = g_write;
      out_addr_d     = g_addr;
      out_tag_d      = g_tag;
      out_ch_d       = gnt_ch;
    end
    evt_hazard_d = |(in_valid & blocked);

    inc             = gnt_vld && g_write;
    inc_idx         = hash_f(g_addr[2*HASH_BITS-1:0]);
    dec_idx         = hash_f(cpl_addr[2*HASH_BITS-1:0]);
    cnt_d           = cnt_q;
    err_underflow_d = err_underflow_q || (cpl_valid && cnt_q[dec_idx] == '0);
    // An issue and a completion on the same bucket cancel out.
    if (!(inc && cpl_valid && inc_idx == dec_idx)) begin
      if (inc)
        cnt_d[inc_idx] = cnt_q[inc_idx] + 1'b1;
      if (cpl_valid && cnt_q[dec_idx] != '0)
        cnt_d[dec_idx] = cnt_q[dec_idx] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      rr_q            <= '0;
      out_valid_q     <= 1'b0;
      out_is_write_q  <= 1'b0;
      out_addr_q      <= '0;
      out_tag_q       <= '0;
      out_ch_q        <= '0;
      evt_hazard_q    <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      rr_q            <= rr_d;
      out_valid_q     <= out_valid_d;
      out_is_write_q  <= out_is_write_d;
      out_addr_q      <= out_addr_d;
      out_tag_q       <= out_tag_d;
      out_ch_q        <= out_ch_d;
      evt_hazard_q    <= evt_hazard_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_is_write  = out_is_write_q;
  assign out_addr      = out_addr_q;
  assign out_tag       = out_tag_q;
  assign out_ch        = out_ch_q;
  assign evt_hazard    = evt_hazard_q;
  assign err_underflow = err_underflow_q;
endmodule

// File: tb/tb_cci_mpf_wro_hazard_filter.sv
// Bench for the hazard filter: a RAW-mode and a strict-mode instance share stimulus, each tracked by its own model.
`timescale 1ns/1ps
module tb_cci_mpf_wro_hazard_filter;
  localparam int NCH = 3, AW = 42, TW = 16, CMAX = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NCH-1:0]    in_valid, in_is_write;
  logic [NCH*AW-1:0] in_addr;
  logic [NCH*TW-1:0] in_tag;
  logic              out_ready, cpl_valid;
  logic [AW-1:0]     cpl_addr;

  logic [NCH-1:0] rdy [2];
  logic           ov [2], ow [2], evt [2], err [2];
  logic [AW-1:0]  oaddr [2];
  logic [TW-1:0]  otag [2];
  logic [1:0]     och [2];

  cci_mpf_wro_hazard_filter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .HASH_BITS(9), .CNT_BITS(2),
                              .MODE(1), .TAG_WIDTH(TW)) dut_raw (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_is_write(in_is_write),
    .in_addr(in_addr), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready), .out_is_write(ow[0]),
    .out_addr(oaddr[0]), .out_tag(otag[0]), .out_ch(och[0]), .cpl_valid(cpl_valid), .cpl_addr(cpl_addr),
    .evt_hazard(evt[0]), .err_underflow(err[0]));

  cci_mpf_wro_hazard_filter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .HASH_BITS(9), .CNT_BITS(2),
                              .MODE(0), .TAG_WIDTH(TW)) dut_strict (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_is_write(in_is_write),
    .in_addr(in_addr), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready), .out_is_write(ow[1]),
    .out_addr(oaddr[1]), .out_tag(otag[1]), .out_ch(och[1]), .cpl_valid(cpl_valid), .cpl_addr(cpl_addr),
    .evt_hazard(evt[1]), .err_underflow(err[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state, index 0 = RAW instance, 1 = strict instance.
  int            m_cnt [2][512];
  int            m_rr [2];
  bit            m_ov [2], m_ow [2], m_evt [2], m_err [2];
  logic [AW-1:0] m_addr [2];
  logic [TW-1:0] m_tag [2];
  int            m_ch [2];

  function automatic int hsh(input logic [AW-1:0] a);
    return int'(a % 512) ^ int'((a / 512) % 512);
  endfunction

  function automatic bit blk(input int d, input int c);
    int n;
    n = m_cnt[d][hsh(in_addr[c*AW +: AW])];
    if (d == 1 || !in_is_write[c]) return n != 0;
    return n >= CMAX;
  endfunction

  task automatic model_reset(input int d);
    for (int i = 0; i < 512; i++) m_cnt[d][i] = 0;
    m_rr[d] = 0; m_ov[d] = 0; m_ow[d] = 0; m_evt[d] = 0; m_err[d] = 0;
    m_addr[d] = '0; m_tag[d] = '0; m_ch[d] = 0;
  endtask

  task automatic model_step(input int d);
    int g = -1;
    bit haz = 0;
    bit slot, inc;
    int hi = -1, hc;
    logic [NCH-1:0] er = '0;
    slot = !m_ov[d] || out_ready;
    for (int k = 0; k < NCH; k++) begin
      int c = (m_rr[d] + k) % NCH;
      if (in_valid[c] && blk(d, c)) haz = 1;
      else if (in_valid[c] && slot && g < 0) g = c;
    end
    if (g >= 0) er[g] = 1'b1;
    chk($sformatf("d%0d in_ready", d), 64'(rdy[d]), 64'(er));
    hc  = hsh(cpl_addr);
    inc = (g >= 0) && in_is_write[g];
    if (inc) hi = hsh(in_addr[g*AW +: AW]);
    if (cpl_valid && m_cnt[d][hc] == 0) m_err[d] = 1;
    if (!(inc && cpl_valid && hc == hi)) begin
      if (inc) m_cnt[d][hi]++;
      if (cpl_valid && m_cnt[d][hc] > 0) m_cnt[d][hc]--;
    end
    if (g >= 0) begin
      m_ov[d] = 1; m_ow[d] = in_is_write[g]; m_ch[d] = g;
      m_addr[d] = in_addr[g*AW +: AW]; m_tag[d] = in_tag[g*TW +: TW];
      m_rr[d] = (g + 1) % NCH;
    end else if (out_ready) begin
      m_ov[d] = 0;
    end
    m_evt[d] = haz;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) model_reset(d);
      chk($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(m_ov[d]));
      chk($sformatf("d%0d out_is_write", d), 64'(ow[d]), 64'(m_ow[d]));
      chk($sformatf("d%0d out_addr", d), 64'(oaddr[d]), 64'(m_addr[d]));
      chk($sformatf("d%0d out_tag", d), 64'(otag[d]), 64'(m_tag[d]));
      chk($sformatf("d%0d out_ch", d), 64'(och[d]), 64'(m_ch[d]));
      chk($sformatf("d%0d evt_hazard", d), 64'(evt[d]), 64'(m_evt[d]));
      chk($sformatf("d%0d err_underflow", d), 64'(err[d]), 64'(m_err[d]));
      if (!reset_n) chk($sformatf("d%0d in_ready in reset", d), 64'(rdy[d]), 64'd0);
      else          model_step(d);
    end
  end

  int             focus = 0;
  bit             hold_all = 0;
  logic [NCH-1:0] acc;

  task automatic put(input int c, input bit w, input logic [AW-1:0] a, input logic [TW-1:0] t);
    in_valid[c] = 1'b1; in_is_write[c] = w;
    in_addr[c*AW +: AW] = a; in_tag[c*TW +: TW] = t;
  endtask

  // One clock: note what the focused instance accepted, then retire accepted requests and completions.
  task automatic cyc();
    @(negedge clk); #1;
    acc = rdy[focus];
    @(posedge clk); #1;
    if (!hold_all) in_valid = in_valid & ~acc;
    cpl_valid = 1'b0;
  endtask

  task automatic cpl(input logic [AW-1:0] a);
    cpl_valid = 1'b1; cpl_addr = a;
  endtask

  task automatic do_reset();
    in_valid = '0; reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; in_valid = '0; in_is_write = '0; in_addr = '0; in_tag = '0;
    out_ready = 1'b1; cpl_valid = 1'b0; cpl_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset in the middle of traffic clears bucket state and the output register.
    put(0, 1, 42'h500, 16'h0501); cyc();
    chk("t1 write issued", 64'(oaddr[0]), 64'h500);
    put(1, 0, 42'h500, 16'h0502); cyc();
    chk("t1 read held", 64'(acc), 64'd0);
    reset_n = 1'b0; #1;
    chk("t1 reset out_valid", 64'(ov[0]), 64'd0);
    chk("t1 reset in_ready", 64'(rdy[0]), 64'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    chk("t1 read after reset", 64'(acc), 64'b010);
    chk("t1 read tag", 64'(otag[0]), 64'h0502);
    chk("t1 read ch", 64'(och[0]), 64'd1);

    // RAW: read behind an outstanding write waits for its completion.
    do_reset();
    put(1, 1, 42'h100, 16'h0A01); cyc();
    chk("t2 write ch", 64'(och[0]), 64'd1);
    put(0, 0, 42'h100, 16'h0A02); cyc(); cyc();
    chk("t2 read stalled", 64'(acc), 64'd0);
    chk("t2 hazard event", 64'(evt[0]), 64'd1);
    cpl(42'h100); cyc();
    chk("t2 held in cpl cycle", 64'(acc), 64'd0);
    cyc();
    chk("t2 read issued", 64'(acc), 64'b001);
    chk("t2 read tag", 64'(otag[0]), 64'h0A02);

    // RAW with 2-bit counters: the fourth write to one bucket saturates it.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(0, 1, 42'h200, 16'h0200 + 16'(i)); cyc();
      chk($sformatf("t3 write%0d issued", i), 64'(acc), 64'b001);
    end
    put(0, 1, 42'h200, 16'h0203); cyc(); cyc();
    chk("t3 fourth held", 64'(acc), 64'd0);
    cpl(42'h200); cyc();
    chk("t3 held in cpl cycle", 64'(acc), 64'd0);
    cyc();
    chk("t3 fourth issued", 64'(acc), 64'b001);
    chk("t3 fourth tag", 64'(otag[0]), 64'h0203);

    // Strict: WAW on 0x300 waits, 0x301 hashes elsewhere and flows.
    do_reset(); focus = 1;
    put(0, 1, 42'h300, 16'h0300); cyc();
    chk("t4 first write", 64'(oaddr[1]), 64'h300);
    put(0, 1, 42'h300, 16'h0301); put(1, 1, 42'h301, 16'h0302); cyc();
    chk("t4 other bucket flows", 64'(acc), 64'b010);
    chk("t4 other bucket addr", 64'(oaddr[1]), 64'h301);
    cyc();
    chk("t4 waw held", 64'(acc), 64'd0);
    chk("t4 hazard event", 64'(evt[1]), 64'd1);
    cpl(42'h300); cyc(); cyc();
    chk("t4 waw issued", 64'(acc), 64'b001);
    chk("t4 waw tag", 64'(otag[1]), 64'h0301);

    // Round robin with all channels busy, then downstream backpressure.
    do_reset(); focus = 0; hold_all = 1;
    put(0, 0, 42'h1000, 16'h5000); put(1, 0, 42'h2000, 16'h5001); put(2, 0, 42'h3000, 16'h5002);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("t5 grant%0d ch", k), 64'(och[0]), 64'(k % 3));
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("t5 stall%0d no accept", k), 64'(acc), 64'd0);
      chk($sformatf("t5 stall%0d addr", k), 64'(oaddr[0]), 64'h3000);
    end
    out_ready = 1'b1; cyc();
    chk("t5 resume ch", 64'(och[0]), 64'd0);
    hold_all = 0; in_valid = '0; cyc(); cyc();
    chk("t5 drained", 64'(ov[0]), 64'd0);

    // Same-bucket issue and completion cancel; completion on an empty bucket is sticky.
    do_reset();
    put(0, 1, 42'h400, 16'h0600); cyc();
    put(0, 1, 42'h400, 16'h0601); cpl(42'h400); cyc();
    chk("t6 write with cpl", 64'(acc), 64'b001);
    put(1, 0, 42'h400, 16'h0602); cyc(); cyc();
    chk("t6 read held cnt1", 64'(acc), 64'd0);
    cpl(42'h400); cyc(); cyc();
    chk("t6 read issued", 64'(acc), 64'b010);
    chk("t6 no underflow yet", 64'(err[0]), 64'd0);
    cpl(42'h400); cyc();
    chk("t6 underflow set", 64'(err[0]), 64'd1);
    cyc(); cyc();
    chk("t6 underflow sticky", 64'(err[0]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
